// File: rtl/host_uart_pkg.sv
// Shared types and constants for the host-side UART receiver.
package host_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; when empty, dout holds the last popped entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/host_uart_rx.sv
// 8N1 UART receiver for the CPU Tx line, buffering bytes in a show-ahead FIFO
// and flagging framing errors and overflow as sticky bits.
module host_uart_rx
  import host_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rx_p0;
  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 push_p1;
  logic                 full;
  logic                 stop_bad;
  logic                 drop;

  // Input synchronizer: idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame FSM: samples mid-bit; the push is registered one cycle behind the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_p1 <= 1'b0;
    end else begin
      push_p1 <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              push_p1 <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_bad = (state == STOP) && (cnt == FULL_M1) && !rx_s;
  assign drop     = push_p1 && full && !rd_en;

  // Sticky flags: a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= stop_bad | (frame_err & ~clr_err);
      overflow  <= drop | (overflow & ~clr_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_p1),
    .pop   (rd_en),
    .din   (shreg),
    .dout  (rd_data),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: tb/tb_host_uart_rx.sv
// Directed bench for host_uart_rx: single byte, back-to-back, glitch, framing
// error, overflow with simultaneous pop, and asynchronous reset mid-frame.
module tb_host_uart_rx;
  import host_uart_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       empty;
  logic [2:0] count;
  logic       frame_err;
  logic       overflow;

  int n_pass   = 0;
  int n_checks = 0;

  host_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drive_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_head(d);
    drive_bit(1'b1);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] e);
    check(tag, 32'(rd_data), 32'(e));
    pop_one();
  endtask

  initial begin
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty",     32'(empty),     32'd1);
    check("rst_count",     32'(count),     32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte with exact push timing
    drive_head(8'h55);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    check("single_empty_at_sample", 32'(empty), 32'd1);
    @(negedge clk);
    check("single_empty_after", 32'(empty),   32'd0);
    check("single_count",       32'(count),   32'd1);
    check("single_data",        32'(rd_data), 32'h55);
    repeat (4) @(negedge clk);
    pop_one();
    check("single_pop_empty", 32'(empty),   32'd1);
    check("single_pop_count", 32'(count),   32'd0);
    check("single_pop_stale", 32'(rd_data), 32'h55);

    // Back-to-back frames
    send_byte(8'hA3);
    send_byte(8'h00);
    send_byte(8'hFF);
    check("b2b_count",     32'(count),     32'd3);
    check("b2b_frame_err", 32'(frame_err), 32'd0);
    check("b2b_overflow",  32'(overflow),  32'd0);
    pop_expect("b2b_d0", 8'hA3);
    pop_expect("b2b_d1", 8'h00);
    pop_expect("b2b_d2", 8'hFF);
    check("b2b_empty", 32'(empty), 32'd1);

    // Glitch shorter than half a bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_count", 32'(count),     32'd0);
    check("glitch_state", 32'(dut.state), 32'(IDLE));
    send_byte(8'h81);
    check("glitch_rx_count", 32'(count),   32'd1);
    check("glitch_rx_data",  32'(rd_data), 32'h81);
    pop_one();

    // Framing error followed by a held-low line
    drive_head(8'h3C);
    rx = 1'b0;
    repeat (CPB + 40) @(negedge clk);
    check("ferr_flag",  32'(frame_err), 32'd1);
    check("ferr_count", 32'(count),     32'd0);
    check("ferr_state", 32'(dut.state), 32'(WAIT_IDLE));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_idle", 32'(dut.state), 32'(IDLE));
    send_byte(8'h81);
    check("ferr_rx_count", 32'(count),   32'd1);
    check("ferr_rx_data",  32'(rd_data), 32'h81);
    pop_one();
    check("ferr_sticky", 32'(frame_err), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Overflow, then pop coinciding with the push of a sixth byte
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    check("ovf_count", 32'(count),    32'd4);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_head",  32'(rd_data),  32'h01);
    drive_head(8'h06);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("ovf_pushpop_count", 32'(count), 32'd4);
    repeat (4) @(negedge clk);
    pop_expect("ovf_d0", 8'h02);
    pop_expect("ovf_d1", 8'h03);
    pop_expect("ovf_d2", 8'h04);
    pop_expect("ovf_d3", 8'h06);
    check("ovf_empty",       32'(empty),    32'd1);
    check("ovf_flag_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset during data bit 3 of 0xC7, with one byte buffered
    send_byte(8'h11);
    check("prerst_count", 32'(count), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_empty",     32'(empty),     32'd1);
    check("arst_count",     32'(count),     32'd0);
    check("arst_rd_data",   32'(rd_data),   32'd0);
    check("arst_overflow",  32'(overflow),  32'd0);
    check("arst_frame_err", 32'(frame_err), 32'd0);
    check("arst_state",     32'(dut.state), 32'(IDLE));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h5A);
    check("postrst_count",     32'(count),     32'd1);
    check("postrst_data",      32'(rd_data),   32'h5A);
    check("postrst_frame_err", 32'(frame_err), 32'd0);
    check("postrst_overflow",  32'(overflow),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
